// File: rtl/ttable_autosym_probe_if.sv
// ttable_autosym_probe_if: handshake and probe bus between the autosymmetry probe and its driver.
interface ttable_autosym_probe_if #(parameter int N_IN = 8);
  logic            start;
  logic [N_IN-1:0] probe_x;
  logic            probe_y;
  logic            busy;
  logic            done;
  logic [N_IN:0]   sym_count;
  modport master (output start, probe_y, input probe_x, busy, done, sym_count);
  modport slave  (input start, probe_y, output probe_x, busy, done, sym_count);
endinterface

// File: rtl/ttable_autosym_probe.sv
// ttable_autosym_probe: captures a truth table via probe_x/probe_y and counts |L_f|.
// Define AUTOSYM_EARLY_EXIT_EN to abandon an alpha on its first mismatch.
module ttable_autosym_probe #(parameter int N_IN = 8) (
  input logic clk,
  input logic rst_n,
  ttable_autosym_probe_if.slave bus
);
  localparam int DEPTH = 1 << N_IN;
`ifdef AUTOSYM_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CAPTURE, SCAN, DONE} state_t;
  state_t          r_state, w_next;
  logic [N_IN-1:0] r_probe_x, r_x, r_alpha;
  logic [N_IN:0]   r_count, r_sym;
  logic            r_busy, r_done, r_flag;
  logic [DEPTH-1:0] r_table;
  logic            w_mis, w_alpha_end, w_sym_ok;
  assign w_mis       = r_table[r_x] ^ r_table[r_x ^ r_alpha];
  assign w_alpha_end = (&r_x) | (EARLY & w_mis);
  assign w_sym_ok    = ~(r_flag | w_mis);
  assign bus.probe_x   = r_probe_x;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sym_count = r_sym;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start ? CAPTURE : IDLE;
      CAPTURE: w_next = (&r_probe_x) ? SCAN : CAPTURE;
      SCAN:    w_next = (w_alpha_end && (&r_alpha)) ? DONE : SCAN;
      default: w_next = IDLE;
    endcase
  end
  // table contents are don't-care after reset, so no reset term here
  always_ff @(posedge clk)
    if (r_state == CAPTURE) r_table[r_probe_x] <= bus.probe_y;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_probe_x <= '0;
      r_x       <= '0;
      r_alpha   <= '0;
      r_flag    <= 1'b0;
      r_count   <= '0;
      r_sym     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_busy    <= 1'b1;
          r_probe_x <= '0;
          r_count   <= (N_IN+1)'(1);
        end
        CAPTURE: begin
          r_probe_x <= r_probe_x + 1'b1;
          r_alpha   <= (N_IN)'(1);
          r_x       <= '0;
          r_flag    <= 1'b0;
        end
        SCAN: begin
          r_x     <= w_alpha_end ? '0 : r_x + 1'b1;
          r_flag  <= w_alpha_end ? 1'b0 : (r_flag | w_mis);
          r_alpha <= w_alpha_end ? r_alpha + 1'b1 : r_alpha;
          r_count <= (w_alpha_end && w_sym_ok) ? r_count + 1'b1 : r_count;
        end
        default: begin
          r_sym  <= r_count;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ttable_autosym_probe.sv
// tb_ttable_autosym_probe: random and directed truth tables checked against a cycle-level model.
module tb_ttable_autosym_probe;
  localparam int N = 5;
  localparam int DEPTH = 1 << N;
`ifdef AUTOSYM_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DEPTH-1:0] f_tab = '0;
  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  ttable_autosym_probe_if #(.N_IN(N)) bus();
  ttable_autosym_probe #(.N_IN(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.probe_y = f_tab[bus.probe_x];
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, got, want, $time);
    end
  endtask
  function automatic int sym_of(input logic [DEPTH-1:0] f);
    int s = 0;
    for (int a = 0; a < DEPTH; a++) begin
      bit ok = 1'b1;
      for (int x = 0; x < DEPTH; x++) if (f[x] != f[x ^ a]) ok = 1'b0;
      s += int'(ok);
    end
    return s;
  endfunction
  function automatic int lat_of(input logic [DEPTH-1:0] f);
    int l = DEPTH + 1;
    for (int a = 1; a < DEPTH; a++) begin
      int c = DEPTH;
      if (EARLY)
        for (int x = DEPTH - 1; x >= 0; x--) if (f[x] != f[x ^ a]) c = x + 1;
      l += c;
    end
    return l;
  endfunction
  function automatic logic [DEPTH-1:0] mk_rand(input logic [31:0] m, input logic [31:0] p, input logic [DEPTH-1:0] r);
    logic [DEPTH-1:0] f;
    for (int x = 0; x < DEPTH; x++) f[x] = r[x & int'(m % DEPTH)] ^ (^(32'(x) & p));
    return f;
  endfunction
  logic         m_run = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [N-1:0] m_px = '0;
  logic [N:0]   m_sym = '0;
  int           m_k = 0, m_lat = 0, m_exp = 0;
  // expected outputs derived from edge count since the accepted start
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_px <= '0; m_sym <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_run) begin
        m_k  <= m_k + 1;
        m_px <= (m_k + 1 < DEPTH) ? N'(m_k + 1) : '0;
        if (m_k + 1 == m_lat) begin
          m_run <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1; m_sym <= (N+1)'(m_exp);
        end
      end else if (bus.start) begin
        m_run <= 1'b1; m_busy <= 1'b1; m_k <= 0; m_px <= '0;
        m_exp <= sym_of(f_tab); m_lat <= lat_of(f_tab);
      end
    end
  end
  always @(negedge clk) if (rst_n) begin
    chk("probe_x", 32'(bus.probe_x), 32'(m_px));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("sym_count", 32'(bus.sym_count), 32'(m_sym));
    if (bus.done) done_cnt++;
  end
  task automatic run(input logic [DEPTH-1:0] f, input bit hold, output int lat, output int sym);
    int k = 0;
    int d0 = done_cnt;
    f_tab = f;
    bus.start = 1'b1;
    @(posedge clk);
    for (;;) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (bus.done || k >= 4 * DEPTH * DEPTH) break;
      @(posedge clk);
      k++;
    end
    bus.start = 1'b0;
    if (!bus.done) chk("done_timeout", 32'(k), 32'(lat_of(f)));
    lat = k;
    sym = int'(bus.sym_count);
    @(negedge clk);
    @(negedge clk);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
  endtask
  logic [DEPTH-1:0] f_x0, f_x01, f_and, fr;
  int lat, sym, d0;
  bit hold;
  initial begin
    bus.start = 1'b0;
    for (int x = 0; x < DEPTH; x++) begin
      f_x0[x]  = x[0];
      f_x01[x] = x[0] ^ x[1];
      f_and[x] = (x == DEPTH - 1);
    end
    #1;
    chk("rst_probe_x", 32'(bus.probe_x), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sym", 32'(bus.sym_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("model_sym_zero", 32'(sym_of('0)), 32);
    chk("model_lat_zero", 32'(lat_of('0)), 1025);
    chk("model_sym_and", 32'(sym_of(f_and)), 1);
    chk("model_lat_and", 32'(lat_of(f_and)), EARLY ? 529 : 1025);
    run('0, 1'b0, lat, sym);
    chk("zero_sym", 32'(sym), 32);
    chk("zero_lat", 32'(lat), 1025);
    chk("sym_hold", 32'(bus.sym_count), 32);
    run(f_x0, 1'b0, lat, sym);
    chk("x0_sym", 32'(sym), 16);
    run(f_x01, 1'b0, lat, sym);
    chk("x0x1_sym", 32'(sym), 16);
    run(f_and, 1'b0, lat, sym);
    chk("and_sym", 32'(sym), 1);
    chk("and_lat", 32'(lat), EARLY ? 529 : 1025);
    run(f_x0, 1'b1, lat, sym);
    chk("hold_sym", 32'(sym), 16);
    f_tab = f_and;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (DEPTH + 50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_probe_x", 32'(bus.probe_x), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_sym", 32'(bus.sym_count), 0);
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (DEPTH * DEPTH + 20) @(negedge clk);
    chk("no_done_after_rst", 32'(done_cnt - d0), 0);
    run(f_x01, 1'b0, lat, sym);
    chk("post_rst_sym", 32'(sym), 16);
    for (int i = 0; i < 10; i++) begin
      fr = mk_rand($urandom, $urandom, DEPTH'($urandom));
      hold = 1'($urandom_range(0, 1));
      run(fr, hold, lat, sym);
      chk("rand_sym", 32'(sym), 32'(sym_of(fr)));
      chk("rand_lat", 32'(lat), 32'(lat_of(fr)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ttable_autosym_probe.md
# ttable_autosym_probe

Sequential probe that drives an N_IN-input single-output combinational benchmark function, captures its full truth table, and then measures its autosymmetry. The measure is the size of the linear space L_f = {α : f(x) = f(x⊕α) for all x}. It sits on the opposite side of the benchmark function's input/output interface: it generates every input vector x, reads back the output, and reports how strongly the function is autosymmetric. It is used on-chip to check optimised benchmark netlists against their expected autosymmetry degree.

## Interface
- N_IN, 8, number of function inputs; truth-table depth is 2^N_IN; legal range 2..10.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a run; sampled only in IDLE.
- probe_x  out  N_IN  input vector driven to the function under test; registered.
- probe_y  in  1  function output for the current probe_x; combinational from probe_x, sampled on the same edge.
- busy  out  1  high from the accepted start edge until the done pulse.
- done  out  1  one-cycle pulse; sym_count valid from that cycle onward.
- sym_count  out  N_IN+1  |L_f|, counting α=0; always a power of two, range 1..2^N_IN.

## Operation
- States: IDLE, CAPTURE, SCAN, DONE.
- IDLE: start=1 at an edge moves to CAPTURE; busy←1, probe_x←0, internal count←1.
- CAPTURE: each edge writes table[probe_x]←probe_y, then probe_x←probe_x+1.
  - After writing entry 2^N_IN−1, go to SCAN with α←1, x←0.
  - probe_x wraps to 0 and holds at 0 outside CAPTURE.
- SCAN: each cycle compares table[x] with table[x⊕α] and accumulates a per-α mismatch flag.
  - At x=2^N_IN−1, if no mismatch occurred for this α (including that final compare), count←count+1.
  - Then α←α+1, x←0, flag cleared.
  - After α=2^N_IN−1 completes, go to DONE.
- DONE: sym_count←count, done←1 for exactly this cycle, busy←0, then IDLE.
- sym_count holds its last result until the next DONE. It is not cleared on start.
- start while busy: ignored; no restart, no queuing.
- Reset at any time: state←IDLE, all outputs to reset values, any partial run is abandoned, no done pulse. Table contents are don't-care.
- Reset values: probe_x=0, busy=0, done=0, sym_count=0.
- Counter widths: x and α are N_IN bits; count is N_IN+1 bits so it can hold 2^N_IN without overflow.

## Timing
- probe_y must settle within one clk period of probe_x changing; no wait states.
- CAPTURE: exactly 2^N_IN cycles.
- SCAN without early exit: (2^N_IN−1)·2^N_IN cycles.
- done rises 2^(2·N_IN)+1 edges after the start edge; 65537 for N_IN=8.
- busy and done are never high in the same cycle.
- A new start is accepted on the edge after the done cycle at the earliest.

## Configuration
- AUTOSYM_EARLY_EXIT_EN defined: on the first mismatch for α, SCAN advances α on the next cycle. A non-symmetric α costs (index of first mismatching x)+1 cycles; a symmetric α still costs 2^N_IN cycles. sym_count is unchanged; only latency shrinks.
- AUTOSYM_EARLY_EXIT_EN undefined: every α is swept over the full 2^N_IN vectors, giving fixed latency 2^(2·N_IN)+1.

## Test plan
All scenarios use N_IN=8.
- f≡0, macro off: start pulse → done exactly 65537 edges later, sym_count=256, busy high throughout.
- f=x0, macro off: sym_count=128 (all α with α0=0).
- f=x0⊕x1, macro off: sym_count=128 (α0=α1). f=x0&x1&…&x7: sym_count=1.
- f=AND of all inputs, macro on: sym_count=1, done 32897 edges after start (256 + Σ_{α=1..255}(256−α) + 1).
- Robustness, all of:
  - start held high during the run → exactly one done pulse.
  - rst_n low mid-SCAN → probe_x=0, busy=0, done=0, sym_count=0 immediately; no done pulse.
  - after reset release, a fresh start reproduces the correct result.
- Back-to-back runs f≡0 then f=x0: sym_count stays 256 until the second done, then reads 128.
